// File: rtl/nlprg_pkg.sv
// Shared definitions for the nlprg arbiter family: sequencer state encoding,
// default parameter values and a pointer-width helper.
package nlprg_pkg;

   localparam int N_DEF       = 8;
   localparam int R_DEF       = 4;
   localparam int RST_CYC_DEF = 2;
   localparam int WARMUP_DEF  = 4;

   typedef enum logic [1:0] {
      SEED = 2'd0,
      WARM = 2'd1,
      RUN  = 2'd2
   } state_e;

   // Width of a requester index; a single requester still gets one bit.
   function automatic int ptr_w(input int r);
      return (r > 1) ? $clog2(r) : 1;
   endfunction

endpackage

// File: rtl/nlprg_rr_pick.sv
// Combinational round-robin priority picker: first set request bit at or
// after the pointer, wrapping modulo R. Outputs one-hot pick, encoded index
// and an any-request flag.
module nlprg_rr_pick
   import nlprg_pkg::*;
#(
   parameter int R  = R_DEF,
   parameter int PW = ptr_w(R)
) (
   input  logic [R-1:0]  req_i,
   input  logic [PW-1:0] ptr_i,
   output logic [R-1:0]  pick_o,
   output logic [PW-1:0] idx_o,
   output logic          any_o
);

   // Rotating scan from the pointer; the first hit wins.
   always_comb begin
      int j;
      pick_o = '0;
      idx_o  = '0;
      any_o  = 1'b0;
      j      = 0;
      for (int i = 0; i < R; i++) begin
         j = int'(ptr_i) + i;
         if (j >= R) j = j - R;
         if (!any_o && req_i[j]) begin
            any_o     = 1'b1;
            pick_o[j] = 1'b1;
            idx_o     = PW'(j);
         end
      end
   end

endmodule

// File: rtl/nlprg_arb.sv
// Round-robin arbiter sharing one free-running nlprg stream among R
// requesters. Sequences PRNG reset (SEED), discards a warm-up window (WARM),
// then grants at most one PRNG value per cycle (RUN).
// Optional period health monitor enabled by defining NLPRG_ARB_HEALTH_EN.
//
// Handshake: req is a level; a request high at edge t in RUN may be granted
// at t, in which case gnt (one-hot) and dat are valid for exactly the cycle
// after t. There is no back-pressure; a granted value is consumed.
module nlprg_arb
   import nlprg_pkg::*;
#(
   parameter int N       = N_DEF,
   parameter int R       = R_DEF,
   parameter int RST_CYC = RST_CYC_DEF,
   parameter int WARMUP  = WARMUP_DEF
) (
   input  logic         ck,
   input  logic         rst,
   input  logic [N-1:0] prng_o,
   output logic         prng_rst,
   input  logic         reseed,
   input  logic [R-1:0] req,
   output logic [R-1:0] gnt,
   output logic [N-1:0] dat,
   output logic         busy,
   output logic         health_err,
   output state_e       dbg_state_o
);

   localparam int PW   = ptr_w(R);
   localparam int CMAX = (RST_CYC > WARMUP) ? RST_CYC : WARMUP;
   localparam int CW   = $clog2(CMAX + 1);

   state_e          state_q;
   logic [CW-1:0]   cnt_q;
   logic            prng_rst_q;
   logic [R-1:0]    gnt_q;
   logic [N-1:0]    dat_q;
   logic            busy_q;
   logic [PW-1:0]   ptr_q;

   logic [R-1:0]    pick;
   logic [PW-1:0]   pick_idx;
   logic            pick_any;
   logic [PW-1:0]   ptr_d;
   logic            health_d;

   nlprg_rr_pick #(.R(R), .PW(PW)) u_pick (
      .req_i  (req),
      .ptr_i  (ptr_q),
      .pick_o (pick),
      .idx_o  (pick_idx),
      .any_o  (pick_any)
   );

   // Pointer moves one past the granted index, wrapping at R.
   assign ptr_d = (pick_idx == PW'(R - 1)) ? '0 : pick_idx + PW'(1);

`ifdef NLPRG_ARB_HEALTH_EN
   logic [N-1:0] pc_q;
   logic         health_q;
   logic         mismatch;

   // The stream restarts at 0, so a zero output must coincide with pc==0.
   assign mismatch = (state_q != SEED) && ((prng_o == '0) != (pc_q == '0));
   assign health_d = health_q | mismatch;

   // Period counter and sticky error flag; only rst clears the flag.
   always_ff @(posedge ck) begin
      if (rst) begin
         pc_q     <= '0;
         health_q <= 1'b0;
      end else begin
         health_q <= health_d;
         if (state_q == SEED) pc_q <= '0;
         else                 pc_q <= pc_q + N'(1);
      end
   end

   assign health_err = health_q;
`else
   assign health_d   = 1'b0;
   assign health_err = 1'b0;
`endif

   // Sequencer FSM with registered grant/data; reseed keeps the pointer.
   always_ff @(posedge ck) begin
      if (rst) begin
         state_q    <= SEED;
         cnt_q      <= '0;
         prng_rst_q <= 1'b1;
         gnt_q      <= '0;
         dat_q      <= '0;
         busy_q     <= 1'b1;
         ptr_q      <= '0;
      end else if (reseed) begin
         state_q    <= SEED;
         cnt_q      <= '0;
         prng_rst_q <= 1'b1;
         gnt_q      <= '0;
         busy_q     <= 1'b1;
      end else begin
         case (state_q)
            SEED: begin
               gnt_q  <= '0;
               busy_q <= 1'b1;
               if (cnt_q == CW'(RST_CYC - 1)) begin
                  state_q    <= WARM;
                  cnt_q      <= '0;
                  prng_rst_q <= 1'b0;
               end else begin
                  cnt_q      <= cnt_q + CW'(1);
                  prng_rst_q <= 1'b1;
               end
            end
            WARM: begin
               prng_rst_q <= 1'b0;
               gnt_q      <= '0;
               if (cnt_q == CW'(WARMUP - 1)) begin
                  state_q <= RUN;
                  cnt_q   <= '0;
                  busy_q  <= health_d;
               end else begin
                  cnt_q  <= cnt_q + CW'(1);
                  busy_q <= 1'b1;
               end
            end
            RUN: begin
               prng_rst_q <= 1'b0;
               busy_q     <= health_d;
               if (pick_any && !health_d) begin
                  gnt_q <= pick;
                  dat_q <= prng_o;
                  ptr_q <= ptr_d;
               end else begin
                  gnt_q <= '0;
               end
            end
            default: begin
               state_q    <= SEED;
               cnt_q      <= '0;
               prng_rst_q <= 1'b1;
               gnt_q      <= '0;
               busy_q     <= 1'b1;
            end
         endcase
      end
   end

   assign prng_rst    = prng_rst_q;
   assign gnt         = gnt_q;
   assign dat         = dat_q;
   assign busy        = busy_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_nlprg_arb.sv
// Directed bench for nlprg_arb (N=8, R=4, RST_CYC=2, WARMUP=4).
// The PRNG stand-in is an 8-bit full-period LCG that restarts at 0 on
// prng_rst; golden() gives its k-th value after reset.
// Health scenarios are built only when NLPRG_ARB_HEALTH_EN is defined.
module tb_nlprg_arb;
   import nlprg_pkg::*;

   logic       ck;
   logic       rst;
   logic [7:0] prng_o;
   logic       prng_rst;
   logic       reseed;
   logic [3:0] req;
   logic [3:0] gnt;
   logic [7:0] dat;
   logic       busy;
   logic       health_err;
   state_e     dbg_state;

   int checks   = 0;
   int failures = 0;

   logic [7:0] s_q;
   logic       force_zero = 1'b0;

   nlprg_arb #(.N(8), .R(4), .RST_CYC(2), .WARMUP(4)) dut (
      .ck          (ck),
      .rst         (rst),
      .prng_o      (prng_o),
      .prng_rst    (prng_rst),
      .reseed      (reseed),
      .req         (req),
      .gnt         (gnt),
      .dat         (dat),
      .busy        (busy),
      .health_err  (health_err),
      .dbg_state_o (dbg_state)
   );

   // clock
   initial ck = 1'b0;
   always #5 ck = ~ck;

   // PRNG stand-in
   always @(posedge ck) begin
      if (prng_rst === 1'b1) s_q <= 8'd0;
      else                   s_q <= s_q * 8'd5 + 8'd1;
   end
   assign prng_o = force_zero ? 8'd0 : s_q;

   function automatic logic [7:0] golden(input int k);
      logic [7:0] v;
      v = 8'd0;
      for (int i = 0; i < k; i++) v = v * 8'd5 + 8'd1;
      return v;
   endfunction

   task automatic tick();
      @(posedge ck);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; reseed = 1'b0; req = 4'b1111;
      repeat (3) tick();
      checks++; if (prng_rst !== 1'b1) begin failures++; $display("FAIL rst_prng_rst got=%0b exp=1", prng_rst); end
      checks++; if (gnt !== 4'b0000) begin failures++; $display("FAIL rst_gnt got=%b exp=0000", gnt); end
      checks++; if (dat !== 8'd0) begin failures++; $display("FAIL rst_dat got=%0d exp=0", dat); end
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL rst_busy got=%0b exp=1", busy); end
      checks++; if (health_err !== 1'b0) begin failures++; $display("FAIL rst_health got=%0b exp=0", health_err); end
      checks++; if (dbg_state !== SEED) begin failures++; $display("FAIL rst_state got=%0d exp=%0d", dbg_state, SEED); end
      rst = 1'b0;
      for (int k = 1; k <= 6; k++) begin
         tick();
         checks++; if (prng_rst !== (k < 2)) begin failures++; $display("FAIL seq_prng_rst k=%0d got=%0b exp=%0b", k, prng_rst, (k < 2)); end
         checks++; if (busy !== (k < 6)) begin failures++; $display("FAIL seq_busy k=%0d got=%0b exp=%0b", k, busy, (k < 6)); end
         checks++; if (gnt !== 4'b0000) begin failures++; $display("FAIL seq_gnt k=%0d got=%b exp=0000", k, gnt); end
      end
      req = 4'b0000;
   endtask

   task automatic test_single();
      logic [7:0] ev;
      req = 4'b0100;
      for (int i = 0; i < 5; i++) begin
         ev = prng_o;
         tick();
         checks++; if (gnt !== 4'b0100) begin failures++; $display("FAIL single_gnt i=%0d got=%b exp=0100", i, gnt); end
         checks++; if (dat !== ev) begin failures++; $display("FAIL single_dat i=%0d got=%0d exp=%0d", i, dat, ev); end
         checks++; if (dat !== golden(4 + i)) begin failures++; $display("FAIL single_golden i=%0d got=%0d exp=%0d", i, dat, golden(4 + i)); end
      end
      req = 4'b0000;
   endtask

   task automatic test_fairness();
      logic [7:0] ev;
      logic [7:0] hold;
      logic [3:0] one;
      int ord[4];
      one = 4'b0001;
      ord = '{0, 2, 3, 0};
      req = 4'b1000;
      tick();
      checks++; if (gnt !== 4'b1000) begin failures++; $display("FAIL fair_align got=%b exp=1000", gnt); end
      req = 4'b1111;
      for (int i = 0; i < 8; i++) begin
         ev = prng_o;
         tick();
         checks++; if (gnt !== (one << (i % 4))) begin failures++; $display("FAIL fair_gnt i=%0d got=%b exp=%b", i, gnt, one << (i % 4)); end
         checks++; if (dat !== ev) begin failures++; $display("FAIL fair_dat i=%0d got=%0d exp=%0d", i, dat, ev); end
      end
      for (int i = 0; i < 4; i++) begin
         if (i == 1) req = 4'b1101;
         tick();
         checks++; if (gnt !== (one << ord[i])) begin failures++; $display("FAIL drop_gnt i=%0d got=%b exp=%b", i, gnt, one << ord[i]); end
      end
      req = 4'b0000;
      hold = dat;
      tick();
      checks++; if (gnt !== 4'b0000) begin failures++; $display("FAIL idle_gnt got=%b exp=0000", gnt); end
      checks++; if (dat !== hold) begin failures++; $display("FAIL idle_dat got=%0d exp=%0d", dat, hold); end
   endtask

   task automatic test_reseed();
      req = 4'b1111;
      tick();
      checks++; if (gnt !== 4'b0010) begin failures++; $display("FAIL rs_pre_gnt got=%b exp=0010", gnt); end
      reseed = 1'b1;
      tick();
      reseed = 1'b0;
      checks++; if (gnt !== 4'b0000) begin failures++; $display("FAIL rs_gnt0 got=%b exp=0000", gnt); end
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL rs_busy0 got=%0b exp=1", busy); end
      checks++; if (prng_rst !== 1'b1) begin failures++; $display("FAIL rs_prng_rst got=%0b exp=1", prng_rst); end
      for (int k = 1; k <= 6; k++) begin
         tick();
         checks++; if (gnt !== 4'b0000) begin failures++; $display("FAIL rs_gnt k=%0d got=%b exp=0000", k, gnt); end
         checks++; if (busy !== (k < 6)) begin failures++; $display("FAIL rs_busy k=%0d got=%0b exp=%0b", k, busy, (k < 6)); end
      end
      tick();
      checks++; if (gnt !== 4'b0100) begin failures++; $display("FAIL rs_resume_gnt got=%b exp=0100", gnt); end
      checks++; if (dat !== golden(4)) begin failures++; $display("FAIL rs_resume_dat got=%0d exp=%0d", dat, golden(4)); end
      req = 4'b0000;
   endtask

   task automatic test_rst_mid_grant();
      req = 4'b0100;
      tick();
      checks++; if (gnt !== 4'b0100) begin failures++; $display("FAIL mid_pre_gnt got=%b exp=0100", gnt); end
      req = 4'b1111; rst = 1'b1; reseed = 1'b1;
      tick();
      rst = 1'b0; reseed = 1'b0;
      checks++; if (gnt !== 4'b0000) begin failures++; $display("FAIL mid_gnt got=%b exp=0000", gnt); end
      checks++; if (dat !== 8'd0) begin failures++; $display("FAIL mid_dat got=%0d exp=0", dat); end
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL mid_busy got=%0b exp=1", busy); end
      tick();
      checks++; if (prng_rst !== 1'b1) begin failures++; $display("FAIL seed_e1 got=%0b exp=1", prng_rst); end
      reseed = 1'b1;
      tick();
      reseed = 1'b0;
      checks++; if (dbg_state !== SEED) begin failures++; $display("FAIL seed_restart_state got=%0d exp=%0d", dbg_state, SEED); end
      checks++; if (prng_rst !== 1'b1) begin failures++; $display("FAIL seed_e2 got=%0b exp=1", prng_rst); end
      tick();
      checks++; if (prng_rst !== 1'b1) begin failures++; $display("FAIL seed_e3 got=%0b exp=1", prng_rst); end
      tick();
      checks++; if (prng_rst !== 1'b0) begin failures++; $display("FAIL seed_e4 got=%0b exp=0", prng_rst); end
      checks++; if (dbg_state !== WARM) begin failures++; $display("FAIL seed_e4_state got=%0d exp=%0d", dbg_state, WARM); end
      repeat (3) tick();
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL seed_e7_busy got=%0b exp=1", busy); end
      tick();
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL seed_e8_busy got=%0b exp=0", busy); end
      tick();
      checks++; if (gnt !== 4'b0001) begin failures++; $display("FAIL ptr_cleared got=%b exp=0001", gnt); end
      checks++; if (dat !== golden(4)) begin failures++; $display("FAIL ptr_cleared_dat got=%0d exp=%0d", dat, golden(4)); end
      req = 4'b0000;
   endtask

`ifdef NLPRG_ARB_HEALTH_EN
   task automatic test_health_fault();
      rst = 1'b1;
      tick();
      rst = 1'b0; req = 4'b1111;
      repeat (19) tick();
      checks++; if (health_err !== 1'b0) begin failures++; $display("FAIL hf_pre got=%0b exp=0", health_err); end
      force_zero = 1'b1;
      tick();
      force_zero = 1'b0;
      checks++; if (health_err !== 1'b1) begin failures++; $display("FAIL hf_set got=%0b exp=1", health_err); end
      checks++; if (gnt !== 4'b0000) begin failures++; $display("FAIL hf_gnt got=%b exp=0000", gnt); end
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL hf_busy got=%0b exp=1", busy); end
      reseed = 1'b1;
      tick();
      reseed = 1'b0;
      repeat (8) tick();
      checks++; if (health_err !== 1'b1) begin failures++; $display("FAIL hf_after_reseed got=%0b exp=1", health_err); end
      checks++; if (gnt !== 4'b0000) begin failures++; $display("FAIL hf_after_reseed_gnt got=%b exp=0000", gnt); end
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL hf_after_reseed_busy got=%0b exp=1", busy); end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++; if (health_err !== 1'b0) begin failures++; $display("FAIL hf_cleared got=%0b exp=0", health_err); end
   endtask

   task automatic test_health_clean();
      int ngnt;
      ngnt = 0;
      req = 4'b1111;
      for (int i = 0; i < 600; i++) begin
         tick();
         if (gnt !== 4'b0000) ngnt++;
      end
      checks++; if (health_err !== 1'b0) begin failures++; $display("FAIL hc_err got=%0b exp=0", health_err); end
      checks++; if (ngnt != 594) begin failures++; $display("FAIL hc_grants got=%0d exp=594", ngnt); end
      req = 4'b0000;
   endtask
`endif

   initial begin
      rst = 1'b1; reseed = 1'b0; req = 4'b0000;
      test_reset();
      test_single();
      test_fairness();
      test_reseed();
      test_rst_mid_grant();
`ifdef NLPRG_ARB_HEALTH_EN
      test_health_fault();
      test_health_clean();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
